// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO: pointer coding helpers,
// default pointer type and read-mode selectors.
package fifo_pkg;

  // Widest pointer the coding helpers handle; narrower pointers are
  // zero-extended on the way in and truncated on the way out.
  localparam int MAX_W = 32;

  // Default geometry: 256-entry RAM, one extra lap bit on each pointer.
  localparam int DEF_ADDR_W = 8;
  localparam int PTR_W      = DEF_ADDR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;

  // Read-side presentation modes.
  localparam bit MODE_STD  = 1'b0;
  localparam bit MODE_FWFT = 1'b1;

  // Binary to reflected Gray. Zero upper bits stay zero, so the result is
  // valid for any width up to MAX_W.
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Reflected Gray to binary. Walks from the MSB down; leading zeros of a
  // zero-extended narrow pointer do not disturb the low bits.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_fwft_stage.sv
// First-word-fall-through output stage: tracks whether the RAM output
// register holds an unread word and prefetches the next one whenever that
// register is free or being consumed, so back-to-back reads have no bubbles.
module fifo_fwft_stage (
  input  logic rclk,
  input  logic rrst_n,
  input  logic rd_en,
  input  logic ram_empty,
  output logic ram_ren,
  output logic valid_next,
  output logic empty
);

  logic valid;

  // Fetch when the output word is absent or leaves this cycle; no fetch in reset.
  always_comb begin
    ram_ren    = rrst_n & ~ram_empty & (~valid | rd_en);
    valid_next = ram_ren | (valid & ~rd_en);
  end

  // Output-register occupancy; empty is kept as its own flop so it is glitch-free.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      valid <= 1'b0;
      empty <= 1'b1;
    end else begin
      valid <= valid_next;
      empty <= ~valid_next;
    end
  end

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-domain controller of the dual-clock FIFO: read pointers (binary and
// Gray), RAM read port, registered empty / almost_empty / occupancy and a
// sticky underflow flag. FWFT selects fall-through or standard presentation.
module async_fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter bit FWFT    = MODE_FWFT,
  parameter int RAM_LAT = 1
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   g_w_ptr_sync,
  input  logic [ADDR_W:0]   ae_level,
  input  logic              clr_underflow,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              ram_ren,
  output logic [ADDR_W:0]   g_r_ptr,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_count,
  output logic              underflow
);

  localparam int PW = ADDR_W + 1;

  // The prefetch timing assumes the RAM output is registered exactly once.
  if (RAM_LAT != 1) begin : g_bad_ram_lat
    $error("async_fifo_rd_ctrl: only RAM_LAT = 1 is supported");
  end

  if (PW > MAX_W) begin : g_bad_addr_w
    $error("async_fifo_rd_ctrl: ADDR_W too wide for pointer helpers");
  end

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] wbin;
  logic [PW-1:0] rd_count_next;
  logic          ram_empty;
  logic          ram_ren_i;
  logic          valid_next;
  logic          empty_i;
  logic          underflow_next;

  assign wbin      = PW'(gray2bin(MAX_W'(g_w_ptr_sync)));
  // Full-width compare: the MSB separates a full lap from an empty FIFO.
  assign ram_empty = (rbin == wbin);

  if (FWFT == MODE_FWFT) begin : g_fwft
    fifo_fwft_stage u_fwft_stage (
      .rclk       (rclk),
      .rrst_n     (rrst_n),
      .rd_en      (rd_en),
      .ram_empty  (ram_empty),
      .ram_ren    (ram_ren_i),
      .valid_next (valid_next),
      .empty      (empty_i)
    );
  end else begin : g_std
    logic empty_q;

    // A read is honoured only while the RAM still holds an unread word.
    assign ram_ren_i  = rrst_n & rd_en & ~empty_q;
    assign valid_next = 1'b0;
    assign empty_i    = empty_q;

    // Empty looks one pointer step ahead so it is exact the cycle after a read.
    always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
        empty_q <= 1'b1;
      end else begin
        empty_q <= (rbin_next == wbin);
      end
    end
  end

  // Next-state arithmetic for pointer, occupancy and sticky flag.
  always_comb begin
    rbin_next      = rbin + PW'(ram_ren_i);
    // In FWFT mode the word parked on the RAM output still counts as stored.
    rd_count_next  = (wbin - rbin_next) + PW'(valid_next);
    // A new underflow outranks a simultaneous clear.
    underflow_next = (rd_en & empty_i) | (underflow & ~clr_underflow);
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin         <= '0;
      g_r_ptr      <= '0;
      rd_count     <= '0;
      almost_empty <= 1'b1;
      underflow    <= 1'b0;
    end else begin
      rbin         <= rbin_next;
      g_r_ptr      <= PW'(bin2gray(MAX_W'(rbin_next)));
      rd_count     <= rd_count_next;
      almost_empty <= (rd_count_next <= ae_level);
      underflow    <= underflow_next;
    end
  end

  assign ram_raddr = rbin[ADDR_W-1:0];
  assign ram_ren   = ram_ren_i;
  assign empty     = empty_i;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Bench for async_fifo_rd_ctrl: one FWFT instance and one standard instance.
// Stimulus queues the expected outputs for each cycle; a monitor on the
// falling clock edge pops and compares them.
module tb_async_fifo_rd_ctrl;

  typedef struct packed {
    logic       ren;
    logic [7:0] raddr;
    logic [8:0] grp;
    logic       empty;
    logic       ae;
    logic [8:0] cnt;
    logic       uf;
  } obs_t;

  typedef struct {
    string name;
    int    idx;
    bit    dut;
    obs_t  v;
  } exp_t;

  logic rclk = 1'b0;
  always #5 rclk = ~rclk;

  // FWFT instance signals
  logic       f_rst_n, f_rd, f_clr, f_ren, f_empty, f_ae, f_uf;
  logic [8:0] f_gw, f_ael, f_grp, f_cnt;
  logic [7:0] f_raddr;
  // Standard-mode instance signals
  logic       s_rst_n, s_rd, s_clr, s_ren, s_empty, s_ae, s_uf;
  logic [8:0] s_gw, s_ael, s_grp, s_cnt;
  logic [7:0] s_raddr;

  async_fifo_rd_ctrl #(.ADDR_W(8), .FWFT(1'b1), .RAM_LAT(1)) u_dut_fwft (
    .rclk(rclk), .rrst_n(f_rst_n), .rd_en(f_rd), .g_w_ptr_sync(f_gw),
    .ae_level(f_ael), .clr_underflow(f_clr), .ram_raddr(f_raddr),
    .ram_ren(f_ren), .g_r_ptr(f_grp), .empty(f_empty),
    .almost_empty(f_ae), .rd_count(f_cnt), .underflow(f_uf)
  );

  async_fifo_rd_ctrl #(.ADDR_W(8), .FWFT(1'b0), .RAM_LAT(1)) u_dut_std (
    .rclk(rclk), .rrst_n(s_rst_n), .rd_en(s_rd), .g_w_ptr_sync(s_gw),
    .ae_level(s_ael), .clr_underflow(s_clr), .ram_raddr(s_raddr),
    .ram_ren(s_ren), .g_r_ptr(s_grp), .empty(s_empty),
    .almost_empty(s_ae), .rd_count(s_cnt), .underflow(s_uf)
  );

  obs_t f_obs, s_obs;
  assign f_obs = {f_ren, f_raddr, f_grp, f_empty, f_ae, f_cnt, f_uf};
  assign s_obs = {s_ren, s_raddr, s_grp, s_empty, s_ae, s_cnt, s_uf};

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [8:0] gray(input logic [8:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic expect_out(input string nm, input int idx, input bit dut,
                            input logic ren, input logic [7:0] ra,
                            input logic [8:0] grp, input logic emp,
                            input logic ae, input logic [8:0] cnt,
                            input logic uf);
    exp_t e;
    e.name = nm;
    e.idx  = idx;
    e.dut  = dut;
    e.v    = {ren, ra, grp, emp, ae, cnt, uf};
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  always @(negedge rclk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      obs_t a;
      e = exp_q.pop_front();
      a = e.dut ? s_obs : f_obs;
      checks++;
      if (a !== e.v) begin
        failures++;
        $display("FAIL %s[%0d] got ren=%b raddr=%h grp=%h empty=%b ae=%b cnt=%0d uf=%b want ren=%b raddr=%h grp=%h empty=%b ae=%b cnt=%0d uf=%b",
                 e.name, e.idx, a.ren, a.raddr, a.grp, a.empty, a.ae, a.cnt, a.uf,
                 e.v.ren, e.v.raddr, e.v.grp, e.v.empty, e.v.ae, e.v.cnt, e.v.uf);
      end
    end
  end

  initial begin
    logic [8:0] cnt;
    logic [8:0] rb;

    f_rst_n = 1'b0; f_rd = 1'b0; f_clr = 1'b0; f_gw = 9'h000; f_ael = 9'd4;
    s_rst_n = 1'b0; s_rd = 1'b0; s_clr = 1'b0; s_gw = 9'h000; s_ael = 9'd0;
    tick();

    // Reset and idle (FWFT)
    expect_out("f_in_reset", 0, 1'b0, 0, 8'h00, 9'h000, 1, 1, 9'd0, 0);
    tick();
    f_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_out("f_idle", i, 1'b0, 0, 8'h00, 9'h000, 1, 1, 9'd0, 0);
      tick();
    end

    // First word falls through
    f_gw = 9'h001;
    expect_out("f_first_fetch", 0, 1'b0, 1, 8'h00, 9'h000, 1, 1, 9'd0, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      expect_out("f_first_held", i, 1'b0, 0, 8'h01, 9'h001, 0, 1, 9'd1, 0);
      tick();
    end

    // Full lap of 256 words read back-to-back
    f_gw = 9'h180;
    f_rd = 1'b1;
    for (int k = 0; k < 256; k++) begin
      cnt = (k == 0) ? 9'd1 : 9'(256 - k);
      rb  = 9'(1 + k);
      expect_out("f_burst1", k, 1'b0, (k < 255), rb[7:0], gray(rb), 0,
                 (cnt <= 9'd4), cnt, 0);
      tick();
    end
    f_rd = 1'b0;
    expect_out("f_drained1", 0, 1'b0, 0, 8'h00, 9'h180, 1, 1, 9'd0, 0);
    tick();

    // Second lap: write pointer wraps to 0, read pointer wraps 511 -> 0
    f_gw = 9'h000;
    expect_out("f_lap_fetch", 0, 1'b0, 1, 8'h00, 9'h180, 1, 1, 9'd0, 0);
    tick();
    f_rd = 1'b1;
    for (int j = 1; j <= 256; j++) begin
      cnt = 9'(257 - j);
      rb  = 9'(256 + j);
      expect_out("f_burst2", j, 1'b0, (j < 256), rb[7:0], gray(rb), 0,
                 (cnt <= 9'd4), cnt, 0);
      tick();
    end
    f_rd = 1'b0;
    expect_out("f_drained2", 0, 1'b0, 0, 8'h00, 9'h000, 1, 1, 9'd0, 0);
    tick();

    // almost_empty threshold at 4 with 6 words
    f_gw = 9'h005;
    expect_out("f_ae_fetch", 0, 1'b0, 1, 8'h00, 9'h000, 1, 1, 9'd0, 0);
    tick();
    expect_out("f_ae_loaded", 0, 1'b0, 0, 8'h01, 9'h001, 0, 0, 9'd6, 0);
    tick();
    f_rd = 1'b1;
    for (int c = 2; c <= 7; c++) begin
      rb  = 9'(c - 1);
      cnt = 9'(8 - c);
      expect_out("f_ae_read", c, 1'b0, (rb != 9'd6), rb[7:0], gray(rb), 0,
                 (cnt <= 9'd4), cnt, 0);
      tick();
    end
    f_rd = 1'b0;
    expect_out("f_ae_empty", 0, 1'b0, 0, 8'h06, 9'h005, 1, 1, 9'd0, 0);
    tick();

    // Underflow set, set-beats-clear, then clear
    f_rd = 1'b1;
    expect_out("f_uf_pulse", 0, 1'b0, 0, 8'h06, 9'h005, 1, 1, 9'd0, 0);
    tick();
    f_rd = 1'b0;
    expect_out("f_uf_set", 0, 1'b0, 0, 8'h06, 9'h005, 1, 1, 9'd0, 1);
    tick();
    f_rd = 1'b1; f_clr = 1'b1;
    expect_out("f_uf_clr_and_set", 0, 1'b0, 0, 8'h06, 9'h005, 1, 1, 9'd0, 1);
    tick();
    f_rd = 1'b0; f_clr = 1'b0;
    expect_out("f_uf_set_wins", 0, 1'b0, 0, 8'h06, 9'h005, 1, 1, 9'd0, 1);
    tick();
    f_clr = 1'b1;
    expect_out("f_uf_clr", 0, 1'b0, 0, 8'h06, 9'h005, 1, 1, 9'd0, 1);
    tick();
    f_clr = 1'b0;
    expect_out("f_uf_cleared", 0, 1'b0, 0, 8'h06, 9'h005, 1, 1, 9'd0, 0);
    tick();

    // Standard mode, ae_level = 0, 3 words available
    s_rd = 1'b1;
    expect_out("s_in_reset", 0, 1'b1, 0, 8'h00, 9'h000, 1, 1, 9'd0, 0);
    tick();
    s_rst_n = 1'b1; s_rd = 1'b0; s_gw = 9'h002;
    expect_out("s_reset", 0, 1'b1, 0, 8'h00, 9'h000, 1, 1, 9'd0, 0);
    tick();
    expect_out("s_loaded", 0, 1'b1, 0, 8'h00, 9'h000, 0, 0, 9'd3, 0);
    tick();
    s_rd = 1'b1;
    expect_out("s_read", 0, 1'b1, 1, 8'h00, 9'h000, 0, 0, 9'd3, 0);
    tick();
    s_rd = 1'b0;
    expect_out("s_after_read", 0, 1'b1, 0, 8'h01, 9'h001, 0, 0, 9'd2, 0);
    tick();
    s_rd = 1'b1;
    expect_out("s_burst", 0, 1'b1, 1, 8'h01, 9'h001, 0, 0, 9'd2, 0);
    tick();
    expect_out("s_burst", 1, 1'b1, 1, 8'h02, 9'h003, 0, 0, 9'd1, 0);
    tick();
    s_rst_n = 1'b0;
    expect_out("s_mid_reset", 0, 1'b1, 0, 8'h00, 9'h000, 1, 1, 9'd0, 0);
    tick();
    expect_out("s_mid_reset", 1, 1'b1, 0, 8'h00, 9'h000, 1, 1, 9'd0, 0);
    tick();
    s_rst_n = 1'b1; s_rd = 1'b0;
    expect_out("s_post_reset", 0, 1'b1, 0, 8'h00, 9'h000, 1, 1, 9'd0, 0);
    tick();
    expect_out("s_post_reset", 1, 1'b1, 0, 8'h00, 9'h000, 0, 0, 9'd3, 0);
    tick();
    s_rd = 1'b1;
    expect_out("s_drain", 0, 1'b1, 1, 8'h00, 9'h000, 0, 0, 9'd3, 0);
    tick();
    expect_out("s_drain", 1, 1'b1, 1, 8'h01, 9'h001, 0, 0, 9'd2, 0);
    tick();
    expect_out("s_drain", 2, 1'b1, 1, 8'h02, 9'h003, 0, 0, 9'd1, 0);
    tick();
    s_rd = 1'b0;
    expect_out("s_empty", 0, 1'b1, 0, 8'h03, 9'h002, 1, 1, 9'd0, 0);
    tick();
    s_rd = 1'b1;
    expect_out("s_uf_pulse", 0, 1'b1, 0, 8'h03, 9'h002, 1, 1, 9'd0, 0);
    tick();
    s_rd = 1'b0;
    expect_out("s_uf_set", 0, 1'b1, 0, 8'h03, 9'h002, 1, 1, 9'd0, 1);
    tick();

    tick();
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
